// File: rtl/next_state_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : next_state_sequencer
// Description : Control-unit state sequencer: fetch, decode, execute and
//               memory-wait states with a moc timeout that parks in a fault.
// Revision    : 1.0 - initial release
// ============================================================================
module next_state_sequencer #(
  parameter int MOC_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic [3:0]  flags,
  input  logic        moc,
  output logic [6:0]  state,
  output logic        busy,
  output logic        mem_wait,
  output logic        fault
);

  typedef enum logic [6:0] {
    S_IDLE       = 7'd0,
    S_MAR_PC     = 7'd1,
    S_FETCH_WAIT = 7'd2,
    S_IR_MDR     = 7'd3,
    S_PC_INC     = 7'd4,
    S_DECODE     = 7'd5,
    S_DP         = 7'd10,
    S_BR         = 7'd20,
    S_BL         = 7'd21,
    S_LD_ADDR    = 7'd30,
    S_LD_WAIT    = 7'd31,
    S_LD_DATA    = 7'd32,
    S_ST_ADDR    = 7'd40,
    S_ST_DATA    = 7'd41,
    S_ST_WAIT    = 7'd42,
    S_UNDEF      = 7'd62,
    S_FAULT      = 7'd63
  } state_t;

  localparam logic [3:0] c_TIMEOUT = 4'(MOC_TIMEOUT);

  state_t     r_state;
  state_t     w_next;
  state_t     w_exec;
  state_t     w_wait_exit;
  logic [3:0] r_cnt;
  logic [3:0] w_next_cnt;
  logic       r_busy;
  logic       r_mem_wait;
  logic       r_fault;
  logic       w_cond_pass;
  logic       w_next_is_wait;
  logic       w_n, w_z, w_c, w_v;
  logic       w_unused_ir;

  assign {w_n, w_z, w_c, w_v} = flags;
  assign w_unused_ir = ^{ir[23:21], ir[19:0]};

  always_comb begin
    w_cond_pass = 1'b0;
    case (ir[31:28])
      4'h0: w_cond_pass = w_z;
      4'h1: w_cond_pass = !w_z;
      4'h2: w_cond_pass = w_c;
      4'h3: w_cond_pass = !w_c;
      4'h4: w_cond_pass = w_n;
      4'h5: w_cond_pass = !w_n;
      4'h6: w_cond_pass = w_v;
      4'h7: w_cond_pass = !w_v;
      4'h8: w_cond_pass = w_c && !w_z;
      4'h9: w_cond_pass = !w_c || w_z;
      4'hA: w_cond_pass = (w_n == w_v);
      4'hB: w_cond_pass = (w_n != w_v);
      4'hC: w_cond_pass = !w_z && (w_n == w_v);
      4'hD: w_cond_pass = w_z || (w_n != w_v);
      4'hE: w_cond_pass = 1'b1;
      4'hF: w_cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    w_exec = S_UNDEF;
    if (!w_cond_pass) begin
      w_exec = S_MAR_PC;
    end else begin
      case (ir[27:25])
        3'b000, 3'b001: w_exec = S_DP;
        3'b010, 3'b011: w_exec = ir[20] ? S_LD_ADDR : S_ST_ADDR;
        3'b101:         w_exec = ir[24] ? S_BL : S_BR;
        default:        w_exec = S_UNDEF;
      endcase
    end
  end

  always_comb begin
    w_wait_exit = S_MAR_PC;
    case (r_state)
      S_FETCH_WAIT: w_wait_exit = S_IR_MDR;
      S_LD_WAIT:    w_wait_exit = S_LD_DATA;
      default:      w_wait_exit = S_MAR_PC;
    endcase
  end

  always_comb begin
    w_next         = S_FAULT;
    w_next_cnt     = r_cnt;
    w_next_is_wait = 1'b0;
    case (r_state)
      S_IDLE:                    w_next = start ? S_MAR_PC : S_IDLE;
      S_MAR_PC:                  w_next = S_FETCH_WAIT;
      S_IR_MDR:                  w_next = S_PC_INC;
      S_PC_INC:                  w_next = S_DECODE;
      S_DECODE:                  w_next = w_exec;
      S_DP, S_BR, S_LD_DATA:     w_next = S_MAR_PC;
      S_BL:                      w_next = S_BR;
      S_LD_ADDR:                 w_next = S_LD_WAIT;
      S_ST_ADDR:                 w_next = S_ST_DATA;
      S_ST_DATA:                 w_next = S_ST_WAIT;
      S_FETCH_WAIT, S_LD_WAIT, S_ST_WAIT: begin
        // moc takes priority over an expiring counter
        if (moc) begin
          w_next = w_wait_exit;
        end else if (r_cnt == c_TIMEOUT) begin
          w_next = S_FAULT;
        end else begin
          w_next     = r_state;
          w_next_cnt = r_cnt + 4'd1;
        end
      end
      default:                   w_next = S_FAULT;
    endcase
    w_next_is_wait = (w_next == S_FETCH_WAIT) || (w_next == S_LD_WAIT) ||
                     (w_next == S_ST_WAIT);
    if (w_next_is_wait && (w_next != r_state)) begin
      w_next_cnt = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_busy     <= 1'b0;
      r_mem_wait <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_next_cnt;
      r_busy     <= (w_next != S_IDLE) && (w_next != S_FAULT);
      r_mem_wait <= w_next_is_wait;
      r_fault    <= (w_next == S_FAULT);
    end
  end

  assign state    = r_state;
  assign busy     = r_busy;
  assign mem_wait = r_mem_wait;
  assign fault    = r_fault;

endmodule
`default_nettype wire
